uart_rx_fifo: RTL and testbench

UART receiver feeding the SoC's serial peripheral from the board line UART_TXD_IN (USB-RS232 bridge -> FPGA).
- Oversamples the line at 16x, validates start bit, deserialises 8N1 frames LSB-first.
- Buffers bytes in a first-word-fall-through FIFO read by the CPU bus bridge.
- Reports framing and overrun errors as sticky flags.

---
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a first-word-fall-through FIFO with sticky error flags.
// Define UART_RX_PARITY_CHECK_EN to receive 8E1 frames and check even parity.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK100MHZ,
    input  logic                          CPU_RESETN,
    input  logic                          rx_i,
    input  logic                          rd_en_i,
    input  logic                          err_clr_i,
    output logic [7:0]                    data_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          frame_err_o,
    output logic                          overrun_err_o,
    output logic                          parity_err_o
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_RX_PARITY_CHECK_EN
        , S_PARITY
`endif
    } state_t;

    state_t r_state, w_next;
    logic r_rx_meta, r_rx_sync, r_rx_prev;
    logic [DW-1:0] r_div;
    logic [3:0] r_tick;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic r_frame_err, r_ovr_err;
    logic w_fall, w_start, w_tick, w_sample, w_stop_smp, w_push, w_par_bad;
    logic [7:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_count;
    logic w_pop, w_full, w_wr, w_ovr;

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_start    = (r_state == S_IDLE) && w_fall;
    assign w_tick     = r_div == DW'(DIV - 1);
    assign w_sample   = w_tick && r_tick == 4'd7;
    assign w_stop_smp = (r_state == S_STOP) && w_sample;
    assign w_push     = w_stop_smp && r_rx_sync && !w_par_bad;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_state   <= w_next;
            r_div     <= (w_start || w_tick) ? '0 : r_div + 1'b1;
            r_tick    <= w_start ? '0 : r_tick + 4'(w_tick);
            if (w_start)
                r_bit <= '0;
            else if (w_sample && r_state == S_DATA) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
        end
    end

    // Stop sample returns to IDLE mid-bit, leaving half a bit of resync margin.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_next = S_START;
            S_START:  if (w_sample) w_next = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (w_sample && r_bit == 3'd7) w_next =
`ifdef UART_RX_PARITY_CHECK_EN
                S_PARITY;
            S_PARITY: if (w_sample) w_next = S_STOP;
`else
                S_STOP;
`endif
            S_STOP:   if (w_sample) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_CHECK_EN
    logic r_par_bad, r_par_err, w_par_set;
    assign w_par_set = (r_state == S_PARITY) && w_sample && (^r_shift ^ r_rx_sync);
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_par_bad <= w_start ? 1'b0 : (r_par_bad | w_par_set);
            r_par_err <= w_par_set | (r_par_err & ~err_clr_i);
        end
    end
    assign w_par_bad    = r_par_bad;
    assign parity_err_o = r_par_err;
`else
    assign w_par_bad    = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_pop  = rd_en_i && r_count != '0;
    assign w_full = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_ovr  = w_push && w_full && !rd_en_i;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_wr        <= r_wr + AW'(w_wr);
            r_rd        <= r_rd + AW'(w_pop);
            r_count     <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            r_frame_err <= (w_stop_smp && !r_rx_sync) | (r_frame_err & ~err_clr_i);
            r_ovr_err   <= w_ovr | (r_ovr_err & ~err_clr_i);
        end
    end

    always_ff @(posedge CLK100MHZ)
        if (w_wr) r_mem[r_wr] <= r_shift;

    assign empty_o       = r_count == '0;
    assign full_o        = w_full;
    assign count_o       = r_count;
    assign data_o        = empty_o ? 8'h00 : r_mem[r_rd];
    assign frame_err_o   = r_frame_err;
    assign overrun_err_o = r_ovr_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames with a scoreboard queue of expected bytes checked by a pop monitor.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int DIVB = 4;
    localparam int BIT_NS = 160 * DIVB;
`ifdef UART_RX_PARITY_CHECK_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif
    // Start edge to push edge: 3 sync clocks plus DIV*(8+16*stop) clocks.
    localparam int PUSH_NS = 29 + 10 * DIVB * (8 + 16 * STOP_IDX);

    logic clk = 0, rst_n = 0, rx = 1, rd_en = 0, err_clr = 0;
    logic [7:0] data_o;
    logic empty_o, full_o, frame_err_o, overrun_err_o, parity_err_o;
    logic [4:0] count_o;
    int total = 0, bad = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.CLK_FREQ(100000000), .BAUD(1500000), .FIFO_DEPTH(16)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .rx_i(rx), .rd_en_i(rd_en), .err_clr_i(err_clr),
        .data_o(data_o), .empty_o(empty_o), .full_o(full_o), .count_o(count_o),
        .frame_err_o(frame_err_o), .overrun_err_o(overrun_err_o), .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n && rd_en && !empty_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h want nothing", data_o);
            end else
                chk("pop_data", data_o, exp_q.pop_front());
        end

    // mode 1: probe push timing; mode 2: pop on the push cycle
    task automatic send(input logic [7:0] b, input bit stop, input bit pflip, input bit push, input int mode);
        @(posedge clk); #1;
        if (push) exp_q.push_back(b);
        rx = 0;
        if (mode == 1) fork
            begin
                #(PUSH_NS - 3) chk("pre_push_empty", empty_o, 1);
                #10 chk("post_push_empty", empty_o, 0);
                chk("post_push_data", data_o, b);
                chk("post_push_count", count_o, 1);
            end
        join_none
        if (mode == 2) fork
            begin
                #(PUSH_NS - 7) rd_en = 1;
                #10 rd_en = 0;
            end
        join_none
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #BIT_NS;
        end
`ifdef UART_RX_PARITY_CHECK_EN
        rx = ^b ^ pflip;
        #BIT_NS;
`endif
        rx = stop;
        #BIT_NS;
        rx = 1;
    endtask

    task automatic rd_pulse();
        @(posedge clk); #1 rd_en = 1;
        @(posedge clk); #1 rd_en = 0;
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b6;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_flags", {frame_err_o, overrun_err_o, parity_err_o}, 0);
        rst_n = 1;
        repeat (5) @(posedge clk);

        send(8'hA5, 1, 0, 1, 1);
        rd_pulse();
        repeat (2) @(posedge clk);
        chk("t1_empty", empty_o, 1);
        chk("t1_count", count_o, 0);

        @(posedge clk); #1 rx = 0;
        #200 rx = 1;
        #(BIT_NS * 2);
        chk("glitch_count", count_o, 0);
        chk("glitch_flags", {frame_err_o, overrun_err_o, parity_err_o}, 0);
        send(8'h3C, 1, 0, 1, 0);
        chk("after_glitch_count", count_o, 1);
        rd_pulse();

        send(8'h3C, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        chk("ferr_set", frame_err_o, 1);
        chk("ferr_count", count_o, 0);
        clr_pulse();
        chk("ferr_clr", frame_err_o, 0);
        fork
            send(8'h3C, 0, 0, 0, 0);
            begin
                #(BIT_NS * 9);
                @(negedge clk) err_clr = 1;
                n = 0;
                while (!frame_err_o && n < BIT_NS) begin
                    @(negedge clk);
                    n++;
                end
                err_clr = 0;
            end
        join
        repeat (3) @(posedge clk);
        chk("ferr_set_wins", frame_err_o, 1);
        clr_pulse();

        for (int i = 0; i < 17; i++) send(8'(i), 1, 0, i < 16, 0);
        chk("fill_full", full_o, 1);
        chk("fill_count", count_o, 16);
        chk("fill_ovr", overrun_err_o, 1);
        repeat (16) rd_pulse();
        repeat (2) @(posedge clk);
        chk("drain_empty", empty_o, 1);
        chk("drain_q", exp_q.size(), 0);
        clr_pulse();
        chk("ovr_clr", overrun_err_o, 0);
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1, 0, 1, 0);
        send(8'h30, 1, 0, 1, 2);
        repeat (2) @(posedge clk);
        chk("pushpop_ovr", overrun_err_o, 0);
        chk("pushpop_count", count_o, 16);
        repeat (16) rd_pulse();
        repeat (2) @(posedge clk);
        chk("wrap_empty", empty_o, 1);
        chk("wrap_q", exp_q.size(), 0);

        send(8'h55, 1, 0, 1, 0);
        send(8'hAA, 1, 0, 1, 0);
        send(8'hFF, 1, 0, 1, 0);
        chk("b2b_count", count_o, 3);
        repeat (3) rd_pulse();
        repeat (2) @(posedge clk);
        chk("b2b_flags", {frame_err_o, overrun_err_o, parity_err_o}, 0);
        rd_pulse();
        chk("rd_empty_count", count_o, 0);
        chk("rd_empty_flag", empty_o, 1);
        chk("rd_empty_data", data_o, 0);

        send(8'h5A, 1, 0, 1, 0);
        chk("pre_rst_count", count_o, 1);
        b6 = 8'h77;
        @(posedge clk); #1 rx = 0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            rx = b6[i];
            #BIT_NS;
        end
        rx = b6[4];
        #(BIT_NS / 2) rst_n = 0;
        #1;
        exp_q.delete();
        chk("mid_rst_empty", empty_o, 1);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_full", full_o, 0);
        #(BIT_NS / 2);
        for (int i = 5; i < 8; i++) begin
            rx = b6[i];
            #BIT_NS;
        end
        rx = 1;
        #(BIT_NS * 2);
        @(posedge clk); #1 rst_n = 1;
        repeat (5) @(posedge clk);
        send(8'h12, 1, 0, 1, 0);
        chk("post_rst_data", data_o, 8'h12);
        rd_pulse();
`ifdef UART_RX_PARITY_CHECK_EN
        send(8'h12, 1, 0, 1, 0);
        chk("par_ok_count", count_o, 1);
        chk("par_ok_flag", parity_err_o, 0);
        rd_pulse();
        send(8'h12, 1, 1, 0, 0);
        repeat (2) @(posedge clk);
        chk("par_bad_flag", parity_err_o, 1);
        chk("par_bad_count", count_o, 0);
`endif
        repeat (4) @(posedge clk);
        chk("final_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
